// File: rtl/wave_capture_buffer.sv
// wave_capture_buffer: captures a triggered window of 2^ADDR_W audio samples
// into one bank of a two-bank RAM. It shows the other bank to the display and
// swaps the banks only on a vsync rising edge, so a frame never tears.
//
// Optional feature: define WAVE_CAPTURE_DECIM_EN to add the decim port.
// Only every 2^decim-th new_sample is then accepted.
//
// Ports:
//   clk          system clock (clk_100)
//   reset_n      asynchronous reset, active-low
//   new_sample   one-cycle strobe that qualifies sample
//   sample       signed audio sample, SAMPLE_W bits
//   vsync        display vertical sync (level, same clock domain)
//   freeze       level; while high, the displayed snapshot is held
//   rd_addr      display read address
//   rd_data      offset-binary sample at rd_addr, 1-cycle latency
//   disp_buf     index of the bank currently shown
//   capture_done one-cycle pulse when a window is complete
//   state_out    current FSM state (debug)
//   decim        (WAVE_CAPTURE_DECIM_EN only) log2 decimation factor
module wave_capture_buffer #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned SAMPLE_W     = 16,
  parameter int unsigned TRIG_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                new_sample,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                vsync,
  input  logic                freeze,
  input  logic [ADDR_W-1:0]   rd_addr,
`ifdef WAVE_CAPTURE_DECIM_EN
  input  logic [1:0]          decim,
`endif
  output logic [7:0]          rd_data,
  output logic                disp_buf,
  output logic                capture_done,
  output logic [1:0]          state_out
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned TO_W  = (TRIG_TIMEOUT > 1) ? $clog2(TRIG_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              prev_neg_q;
  logic              vsync_d;
  logic              disp_d;
  logic              done_d;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;
  logic              sample_msb;
  logic              accept;
  logic              trig;

  // Two banks: {bank, addr}. Contents are deliberately not reset.
  logic [7:0] mem [2*DEPTH];

  // Only the top 8 bits of the sample are stored.
  logic unused_lsbs;
  assign unused_lsbs = ^sample[SAMPLE_W-9:0];

  assign sample_msb = sample[SAMPLE_W-1];
  // Offset binary: flip the sign bit of the top byte.
  assign wdata      = {~sample[SAMPLE_W-1], sample[SAMPLE_W-2 -: 7]};
  assign state_out  = state_q;

`ifdef WAVE_CAPTURE_DECIM_EN
  logic [1:0] decim_q;
  logic [2:0] dcnt_q, dcnt_d;
  logic [2:0] dmask;

  // Accept the last strobe of each group of 2^decim_q strobes.
  assign dmask  = 3'((4'd1 << decim_q) - 4'd1);
  assign accept = new_sample && (dcnt_q == dmask);

  // Decimation counter. It restarts on trigger, so a window is aligned to its first sample.
  always_comb begin
    dcnt_d = dcnt_q;
    if (new_sample) begin
      dcnt_d = accept ? 3'd0 : dcnt_q + 3'd1;
    end
    if (state_q == ST_ARMED && state_d == ST_ACTIVE) begin
      dcnt_d = 3'd0;
    end
  end

  // decim follows the port while armed and is frozen once a capture starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      decim_q <= 2'd0;
      dcnt_q  <= 3'd0;
    end else begin
      dcnt_q <= dcnt_d;
      if (state_q == ST_ARMED) begin
        decim_q <= decim;
      end
    end
  end
`else
  assign accept = new_sample;
`endif

  // Trigger on a rising zero crossing, or when the timeout expires.
  assign trig = (prev_neg_q && !sample_msb) || (to_q == TO_W'(TRIG_TIMEOUT - 1));

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    to_d     = to_q;
    disp_d   = disp_buf;
    done_d   = 1'b0;
    we       = 1'b0;
    waddr    = wr_ptr_q;
    case (state_q)
      ST_ARMED: begin
        if (accept) begin
          if (trig) begin
            we       = 1'b1;
            waddr    = '0;
            wr_ptr_d = ADDR_W'(1);
            to_d     = '0;
            state_d  = ST_ACTIVE;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
      end
      ST_ACTIVE: begin
        if (accept) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
            done_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Samples are dropped here. A swap happens only on an unfrozen vsync rise.
        if (vsync && !vsync_d && !freeze) begin
          disp_d  = ~disp_buf;
          state_d = ST_ARMED;
        end
      end
      default: state_d = ST_ARMED;
    endcase
  end

  // State and control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_ARMED;
      wr_ptr_q     <= '0;
      to_q         <= '0;
      prev_neg_q   <= 1'b0;
      disp_buf     <= 1'b0;
      capture_done <= 1'b0;
      vsync_d      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      to_q         <= to_d;
      disp_buf     <= disp_d;
      capture_done <= done_d;
      vsync_d      <= vsync;
      if (accept) begin
        prev_neg_q <= sample_msb;
      end
    end
  end

  // Write port: always into the hidden bank
  always_ff @(posedge clk) begin
    if (we) begin
      mem[{~disp_buf, waddr}] <= wdata;
    end
  end

  // Read port: registered read from the displayed bank
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= mem[{disp_buf, rd_addr}];
    end
  end

endmodule

// File: tb/tb_wave_capture_buffer.sv
// Scoreboard bench for wave_capture_buffer. Stimulus tasks push expectations
// into queues. A negedge monitor pops an entry and compares it whenever the
// DUT pulses capture_done, read data is due, or a state probe is requested.
module tb_wave_capture_buffer;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned SAMPLE_W = 16;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                new_sample;
  logic [SAMPLE_W-1:0] sample;
  logic                vsync;
  logic                freeze;
  logic [ADDR_W-1:0]   rd_addr;
  logic [7:0]          rd_data;
  logic                disp_buf;
  logic                capture_done;
  logic [1:0]          state_out;
`ifdef WAVE_CAPTURE_DECIM_EN
  logic [1:0]          decim = 2'd0;
`endif

  always #5 clk = ~clk;

  wave_capture_buffer #(
    .ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W), .TRIG_TIMEOUT(1024)
  ) dut (
    .clk(clk), .reset_n(reset_n), .new_sample(new_sample), .sample(sample),
    .vsync(vsync), .freeze(freeze), .rd_addr(rd_addr),
`ifdef WAVE_CAPTURE_DECIM_EN
    .decim(decim),
`endif
    .rd_data(rd_data), .disp_buf(disp_buf), .capture_done(capture_done),
    .state_out(state_out)
  );

  typedef struct {
    int st;
    int disp;
    int rd;   // negative: rd_data not checked
  } probe_t;

  int     done_q[$];
  int     rd_q[$];
  probe_t probe_q[$];
  probe_t mon_p;
  int     errors = 0;
  int     checks = 0;
  int     n_sent = 0;
  logic   rd_req = 1'b0;
  logic   rd_vld = 1'b0;
  logic   probe_req = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) rd_vld <= rd_req;

  // Monitor: compares the DUT against queued expectations.
  always @(negedge clk) begin
    if (capture_done === 1'b1) begin
      if (done_q.size() == 0) check("capture_done_unexpected", 1, 0);
      else check("capture_done_sample_idx", n_sent, done_q.pop_front());
    end
    if (rd_vld) begin
      if (rd_q.size() == 0) check("rd_data_unexpected", 1, 0);
      else check("rd_data", int'(rd_data), rd_q.pop_front());
    end
    if (probe_req) begin
      if (probe_q.size() == 0) check("probe_unexpected", 1, 0);
      else begin
        mon_p = probe_q.pop_front();
        check("state_out", int'(state_out), mon_p.st);
        check("disp_buf", int'(disp_buf), mon_p.disp);
        if (mon_p.rd >= 0) check("rd_data_reset", int'(rd_data), mon_p.rd);
      end
    end
  end

  task automatic send(input logic [15:0] s);
    @(posedge clk); #1;
    new_sample = 1'b1;
    sample     = s;
    n_sent++;
    @(posedge clk); #1;
    new_sample = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic probe_now(input int st, input int disp, input int rd);
    probe_t p;
    p.st = st; p.disp = disp; p.rd = rd;
    probe_q.push_back(p);
    probe_req = 1'b1;
    @(negedge clk); #1;
    probe_req = 1'b0;
  endtask

  task automatic probe(input int st, input int disp);
    @(posedge clk); #1;
    probe_now(st, disp, -1);
  endtask

  task automatic rd_check(input logic [7:0] addr, input int exp);
    @(posedge clk); #1;
    rd_addr = addr;
    rd_q.push_back(exp);
    rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic vsync_pulse();
    @(posedge clk); #1;
    vsync = 1'b1;
    @(posedge clk); #1;
    vsync = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    probe_now(0, 0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    real pi;
    int  v;
    pi         = 3.14159265358979;
    reset_n    = 1'b0;
    new_sample = 1'b0;
    sample     = '0;
    vsync      = 1'b0;
    freeze     = 1'b0;
    rd_addr    = '0;
    repeat (3) @(posedge clk);
    #1;
    probe_now(0, 0, 0);
    check("capture_done_reset", int'(capture_done), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Sine, 64 samples per period. The first rising crossing is sample index 64.
    n_sent = 0;
    done_q.push_back(320);
    for (int i = 0; i < 320; i++) begin
      v = int'(16384.0 * $sin(2.0 * pi * real'(i) / 64.0));
      send(16'(v));
    end
    check("sine_done_seen", done_q.size(), 0);
    probe(2, 0);
    vsync_pulse();
    probe(0, 1);
    rd_check(8'd0, 8'h80);
    rd_check(8'd16, 8'hC0);
    rd_check(8'd48, 8'h40);

    // Constant input: forced trigger on the 1024th sample. Freeze is raised mid-capture.
    do_reset();
    n_sent = 0;
    done_q.push_back(1279);
    for (int i = 0; i < 1023; i++) send(16'h1000);
    probe(0, 0);
    send(16'h1000);
    probe(1, 0);
    for (int i = 0; i < 128; i++) send(16'h1000);
    freeze = 1'b1;
    for (int i = 0; i < 127; i++) send(16'h1000);
    check("timeout_done_seen", done_q.size(), 0);
    probe(2, 0);
    for (int i = 0; i < 3; i++) begin
      vsync_pulse();
      probe(2, 0);
    end
    freeze = 1'b0;
    vsync_pulse();
    probe(0, 1);
    rd_check(8'd5, 8'h90);
    rd_check(8'd255, 8'h90);

    // Reset at wr_ptr=100 during a capture, then a fresh ramp capture.
    send(16'hC000);
    send(16'h2000);
    probe(1, 1);
    for (int i = 0; i < 99; i++) send(16'h2000);
    do_reset();
    n_sent = 0;
    done_q.push_back(257);
    send(16'h8000);
    for (int k = 0; k < 256; k++) send({8'(k), 8'h00});
    check("ramp_done_seen", done_q.size(), 0);
    probe(2, 0);

    // vsync rise and new_sample in the same cycle in WAIT: swap, no write.
    send(16'h8000);
    @(posedge clk); #1;
    vsync      = 1'b1;
    new_sample = 1'b1;
    sample     = 16'h7FFF;
    @(posedge clk); #1;
    vsync      = 1'b0;
    new_sample = 1'b0;
    probe(0, 1);
    rd_check(8'd0, 8'h80);
    rd_check(8'd100, 8'hE4);
    rd_check(8'd255, 8'h7F);
    send(16'h1000);
    probe(0, 1);
    send(16'hF000);
    send(16'h3000);
    probe(1, 1);

    repeat (4) @(posedge clk);
    check("done_q_drained", done_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    check("probe_q_drained", probe_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wave_capture_buffer.md
Name: wave_capture_buffer

Overview:
- Sits between music_player and wave_display_top, in the clk_100 domain.
- Captures a triggered window of 2^ADDR_W audio samples into a double-buffered RAM, starting on a rising zero crossing.
- Presents a stable, frame-synchronised snapshot to the display via a synchronous read port.
- The buffer swap happens only on a vsync rising edge, so the waveform never tears mid-frame.

Parameters:
- ADDR_W, 8, log2 of the capture window length (256 samples).
- SAMPLE_W, 16, input sample width (two's complement).
- TRIG_TIMEOUT, 1024, samples to wait for a zero crossing before forcing a trigger.

Ports:
- clk  in  1  system clock (clk_100).
- reset_n  in  1  asynchronous reset, active-low.
- new_sample  in  1  one-cycle strobe; sample is valid this cycle.
- sample  in  SAMPLE_W  signed audio sample (flopped_sample).
- vsync  in  1  display vertical sync, level, same clock domain.
- freeze  in  1  level; when 1, holds the displayed snapshot.
- rd_addr  in  ADDR_W  display read address.
- rd_data  out  8  offset-binary sample at rd_addr; 1-cycle latency.
- disp_buf  out  1  index of the buffer currently shown.
- capture_done  out  1  one-cycle pulse when a window is complete.
- state_out  out  2  current FSM state (debug).

Behaviour:
- Reset (reset_n=0, async):
  - FSM=ARMED, wr_ptr=0, timeout_cnt=0, prev_neg=0, disp_buf=0.
  - rd_data=0, capture_done=0, vsync_d=0.
  - RAM contents are not reset.
- Storage: two banks of 2^ADDR_W x 8 bits.
  - Stored value = sample[SAMPLE_W-1 -: 8] with the MSB inverted (offset binary): 16'h8000 -> 8'h00, 16'h0000 -> 8'h80, 16'h7FFF -> 8'hFF.
- Writes go to bank ~disp_buf only. Reads come from bank disp_buf only.
- rd_data is registered from RAM[disp_buf][rd_addr] every cycle (latency 1).
- prev_neg updates on every new_sample (= sample MSB), in all states.
- FSM state ARMED (2'd0), on new_sample:
  - Trigger when prev_neg=1 and sample MSB=0: write this sample at address 0, wr_ptr<=1, go to ACTIVE.
  - Otherwise, if timeout_cnt==TRIG_TIMEOUT-1: forced trigger, same action as a trigger.
  - Otherwise timeout_cnt++.
  - timeout_cnt clears on leaving ARMED.
- FSM state ACTIVE (2'd1), on new_sample:
  - Write at wr_ptr, then wr_ptr++.
  - On writing address 2^ADDR_W-1: capture_done=1 for that cycle, wr_ptr wraps to 0, go to WAIT.
- FSM state WAIT (2'd2):
  - new_sample is ignored (no writes); prev_neg still tracks.
  - On a vsync rising edge (vsync=1, vsync_d=0) with freeze=0: toggle disp_buf, go to ARMED.
  - With freeze=1, stay in WAIT and keep the current display bank.
- State 2'd3 is unreachable; if entered, return to ARMED next cycle.
- Simultaneous events:
  - vsync edge and new_sample in the same cycle in WAIT: swap wins; the sample is not written, but prev_neg updates.
  - vsync edge in ARMED or ACTIVE: no effect.
- Freeze asserted mid-ACTIVE: capture completes, then the block holds in WAIT until freeze=0 and the next vsync edge.
- new_sample while held in WAIT: dropped, no overflow condition.
- Async reset mid-capture: the partial window is discarded and disp_buf returns to 0.

Optional Feature:
- Macro: WAVE_CAPTURE_DECIM_EN.
- Defined:
  - Adds port decim [1:0] (in).
  - Only every 2^decim-th new_sample is accepted, via a decimation counter that resets to 0 and clears on ARMED->ACTIVE.
  - Trigger detection and TRIG_TIMEOUT count accepted samples only.
  - decim is sampled on entry to ARMED; mid-capture changes are ignored.
- Undefined: no decim port; every new_sample is accepted.

Test Plan:
- Reset, then a sine (amplitude 16'h4000, 64 samples/period), one new_sample per 4 clocks:
  - First write occurs on the first negative->non-negative sample.
  - capture_done pulses after exactly 256 accepted samples.
  - disp_buf toggles to 1 on the next vsync rise.
  - Reading addr 0 returns 8'h80 one cycle after rd_addr is applied.
- Constant 16'h1000 input: no crossing; forced trigger after 1024 samples; capture_done 256 samples later.
- Window complete, freeze=1, three vsync pulses: disp_buf unchanged, state_out=2.
  - Drop freeze; next vsync rise: disp_buf toggles, state_out=0.
- Assert reset_n=0 for 1 cycle while wr_ptr=100 in ACTIVE:
  - state_out=0, disp_buf=0, rd_data=0 immediately (async).
  - The next trigger restarts writing at address 0.
- In WAIT, apply a vsync rise in the same cycle as new_sample=1 with sample=16'h7FFF:
  - Swap occurs; no RAM write.
  - Next accepted crossing behaves per prev_neg=0.
- With WAVE_CAPTURE_DECIM_EN and decim=2: 1024 new_sample strobes produce one 256-sample window; stored values equal every 4th input.
